// File: rtl/gost89_gamma_ctrl.sv
// GOST 28147-89 gamming (counter-mode) controller driving an external ECB core.
// Define GOST89_GAMMA_PREFETCH_EN to compute the next gamma while the output drains.
module gost89_gamma_ctrl #(
    parameter logic [31:0] C_A = 32'h01010101,
    parameter logic [31:0] C_B = 32'h01010104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] iv,
    output logic        busy,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        core_load,
    output logic [63:0] core_in,
    input  logic        core_busy,
    input  logic [63:0] core_out
);

    typedef enum logic [2:0] {
        IDLE,
        IV_LOAD,
        IV_WAIT,
        CNT_LOAD,
        GAM_WAIT,
        READY
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] cnt_a_reg, cnt_a_next;
    logic [31:0] cnt_b_reg, cnt_b_next;
    logic [63:0] gamma_reg, gamma_next;
    logic        gamma_valid_reg, gamma_valid_next;
    logic        busy_reg, busy_next;
    logic        out_valid_reg, out_valid_next;
    logic [63:0] out_data_reg, out_data_next;
    logic [63:0] core_in_reg, core_in_next;

    logic [63:0] adv_cnt;
    logic [63:0] adv_seed;
    logic        accept;

    // A wraps mod 2^32; B adds with end-around carry (mod 2^32-1 residues).
    function automatic logic [63:0] advance(input logic [63:0] ab);
        logic [32:0] sum_b;
        logic [31:0] next_a;
        logic [31:0] next_b;
        next_a = ab[63:32] + C_A;
        sum_b  = {1'b0, ab[31:0]} + {1'b0, C_B};
        next_b = sum_b[31:0] + {31'd0, sum_b[32]};
        return {next_a, next_b};
    endfunction

    assign adv_cnt  = advance({cnt_a_reg, cnt_b_reg});
    assign adv_seed = advance(core_out);

    // Counters and core_in are advanced on entry to CNT_LOAD so the load cycle
    // already presents the new counter block to the core.
    assign core_load = (state_reg == IV_LOAD) || (state_reg == CNT_LOAD);
    assign in_ready  = (state_reg == READY) && gamma_valid_reg && !start &&
                       (!out_valid_reg || out_ready);
    assign accept    = in_ready && in_valid;

    assign busy      = busy_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign core_in   = core_in_reg;

    always_comb begin
        state_next       = state_reg;
        cnt_a_next       = cnt_a_reg;
        cnt_b_next       = cnt_b_reg;
        gamma_next       = gamma_reg;
        gamma_valid_next = gamma_valid_reg;
        busy_next        = busy_reg;
        out_valid_next   = out_valid_reg;
        out_data_next    = out_data_reg;
        core_in_next     = core_in_reg;

        if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end

        if (start) begin
            state_next       = IV_LOAD;
            core_in_next     = iv;
            busy_next        = 1'b1;
            gamma_valid_next = 1'b0;
            out_valid_next   = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = IDLE;
                end
                IV_LOAD: begin
                    state_next = IV_WAIT;
                end
                IV_WAIT: begin
                    if (!core_busy) begin
                        cnt_a_next   = adv_seed[63:32];
                        cnt_b_next   = adv_seed[31:0];
                        core_in_next = adv_seed;
                        state_next   = CNT_LOAD;
                    end
                end
                CNT_LOAD: begin
                    state_next = GAM_WAIT;
                end
                GAM_WAIT: begin
                    if (!core_busy) begin
                        gamma_next       = core_out;
                        gamma_valid_next = 1'b1;
                        busy_next        = 1'b0;
                        state_next       = READY;
                    end
                end
                READY: begin
                    if (accept) begin
                        out_data_next    = in_data ^ gamma_reg;
                        out_valid_next   = 1'b1;
                        gamma_valid_next = 1'b0;
`ifdef GOST89_GAMMA_PREFETCH_EN
                        cnt_a_next   = adv_cnt[63:32];
                        cnt_b_next   = adv_cnt[31:0];
                        core_in_next = adv_cnt;
                        state_next   = CNT_LOAD;
`endif
                    end
`ifndef GOST89_GAMMA_PREFETCH_EN
                    // Demand-driven: only spin the core once a block is waiting
                    // and the output register has room for its result.
                    else if (!gamma_valid_reg && in_valid &&
                             (!out_valid_reg || out_ready)) begin
                        cnt_a_next   = adv_cnt[63:32];
                        cnt_b_next   = adv_cnt[31:0];
                        core_in_next = adv_cnt;
                        state_next   = CNT_LOAD;
                    end
`endif
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            cnt_a_reg       <= 32'd0;
            cnt_b_reg       <= 32'd0;
            gamma_reg       <= 64'd0;
            gamma_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= 64'd0;
            core_in_reg     <= 64'd0;
        end else begin
            state_reg       <= state_next;
            cnt_a_reg       <= cnt_a_next;
            cnt_b_reg       <= cnt_b_next;
            gamma_reg       <= gamma_next;
            gamma_valid_reg <= gamma_valid_next;
            busy_reg        <= busy_next;
            out_valid_reg   <= out_valid_next;
            out_data_reg    <= out_data_next;
            core_in_reg     <= core_in_next;
        end
    end

endmodule

// File: tb/tb_gost89_gamma_ctrl.sv
// Bench for gost89_gamma_ctrl: identity ECB core model with fixed latency and a
// counter-mode reference model computed with plain modular arithmetic.
module tb_gost89_gamma_ctrl;

    localparam int          LAT = 34;  // load edge to result-visible cycle
    localparam logic [31:0] CA  = 32'h01010101;
    localparam logic [31:0] CB  = 32'h01010104;
`ifdef GOST89_GAMMA_PREFETCH_EN
    localparam int   PERIOD = LAT + 2;
    localparam logic PF     = 1'b1;
`else
    localparam int   PERIOD = LAT + 3;
    localparam logic PF     = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] iv;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        core_load;
    logic [63:0] core_in;
    logic        core_busy;
    logic [63:0] core_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    gost89_gamma_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .iv(iv), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_load(core_load), .core_in(core_in),
        .core_busy(core_busy), .core_out(core_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Identity core: a load restarts it; result appears LAT cycles after the load edge,
    // with noise on core_out while busy so early captures are caught.
    int          core_cnt;
    logic [63:0] core_hold;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
            core_out  <= 64'd0;
            core_hold <= 64'd0;
        end else if (core_load) begin
            core_busy <= 1'b1;
            core_cnt  <= LAT - 1;
            core_hold <= core_in;
            core_out  <= {$urandom, $urandom};
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_busy <= 1'b0;
                core_out  <= core_hold;
            end else begin
                core_out <= {$urandom, $urandom};
            end
        end
    end

    // Reference counters: A mod 2^32, B kept in 1..2^32-1 as GOST's mod (2^32-1) add.
    longint unsigned ma, mb;
    function automatic void mseed(input logic [63:0] v);
        ma = longint'(v[63:32]);
        mb = longint'(v[31:0]);
    endfunction
    function automatic logic [63:0] mgamma();
        ma = (ma + longint'(CA)) % 64'h1_0000_0000;
        mb = ((mb + longint'(CB) - 1) % 64'hFFFF_FFFF) + 1;
        return {ma[31:0], mb[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [63:0] v);
        iv    = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        mseed(v);
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        check(tag, 64'(n), 64'(2 * LAT + 2));
    endtask

    task automatic send(input string tag, input logic [63:0] d);
        logic [63:0] g;
        int          n = 0;
        g        = mgamma();
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_acc"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "_ov"}, 64'(out_valid), 64'd1);
        check({tag, "_od"}, out_data, d ^ g);
        $display("block %s in=%h out=%h", tag, d, out_data);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held, d2, g2, expd;
        logic        stable;
        int          n, last, acc;

        reset = 1'b0; start = 1'b0; iv = 64'd0;
        in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b1;
        tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_core_load", 64'(core_load), 64'd0);
        check("rst_core_in", core_in, 64'd0);
        reset = 1'b1;
        tick();

        // Directed known-answer session from iv=0
        do_start(64'd0);
        check("ivload_core_in", core_in, 64'd0);
        check("ivload_core_load", 64'(core_load), 64'd1);
        wait_busy("t1_busy_len");
        send("t1", 64'd0);
        check("t1_kat", out_data, 64'h01010101_01010104);
        send("t2", 64'hFFFFFFFF_FFFFFFFF);
        check("t2_kat", out_data, 64'hFDFDFDFD_FDFDFDF7);

        // Counter wrap: A to 0, B end-around to 1
        do_start(64'hFEFEFEFF_FEFEFEFC);
        wait_busy("wrap_busy_len");
        send("wrap", 64'd0);
        check("wrap_kat", out_data, 64'h00000000_00000001);

        // Backpressure with a pending second block
        do_start({$urandom, $urandom});
        wait_busy("bp_busy_len");
        out_ready = 1'b0;
        send("bp1", {$urandom, $urandom});
        held     = out_data;
        g2       = mgamma();
        d2       = {$urandom, $urandom};
        in_valid = 1'b1;
        in_data  = d2;
        stable   = 1'b1;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'(PF));
        n = 0;
        while (in_ready !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check("bp2_acc", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp2_od", out_data, d2 ^ g2);
        $display("block bp2 in=%h out=%h", d2, out_data);

        // Restart during GAM_WAIT of a random-iv session
        do_start({$urandom, $urandom});
        repeat (50) tick();
        check("rs_busy_mid", 64'(busy), 64'd1);
        do_start(64'd0);
        wait_busy("rs_busy_len");
        send("rs", 64'd0);
        check("rs_kat", out_data, 64'h01010101_01010104);

        // Randomised sessions
        for (int s = 0; s < 3; s++) begin
            do_start({$urandom, $urandom});
            wait_busy("rnd_busy_len");
            for (int k = 0; k < 3; k++) begin
                repeat ($urandom_range(0, 3)) tick();
                send("rnd", {$urandom, $urandom});
            end
        end

        // Sustained throughput with in_valid held high
        do_start({$urandom, $urandom});
        wait_busy("thr_busy_len");
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
        last = 0; acc = 0; n = 0;
        while (acc < 4 && n < 400) begin
            if (in_ready === 1'b1) begin
                expd = in_data ^ mgamma();
                if (acc > 0) check("thr_gap", 64'(cyc - last), 64'(PERIOD));
                last = cyc;
                acc++;
                tick();
                check("thr_od", out_data, expd);
                $display("block thr cycle=%0d out=%h", last, out_data);
                in_data = {$urandom, $urandom};
            end else begin
                tick();
            end
            n++;
        end
        in_valid = 1'b0;
        check("thr_count", 64'(acc), 64'd4);

        // Asynchronous reset while READY holds an output
        do_start({$urandom, $urandom});
        wait_busy("rr_busy_len");
        out_ready = 1'b0;
        send("rr", {$urandom, $urandom});
        repeat (40) tick();
        out_ready = 1'b1;
        #1;
        check("rr_pre_ready", 64'(in_ready), 64'(PF));
        check("rr_pre_ov", 64'(out_valid), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check("rr_out_valid", 64'(out_valid), 64'd0);
        check("rr_busy", 64'(busy), 64'd0);
        check("rr_in_ready", 64'(in_ready), 64'd0);
        check("rr_core_load", 64'(core_load), 64'd0);
        check("rr_out_data", out_data, 64'd0);
        reset = 1'b1;
        tick();
        check("rr_idle_ready", 64'(in_ready), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
